// File: rtl/register_scoreboard.sv
// register_scoreboard
// Tracks outstanding MUL/DIV writes per architectural register and raises a
// single stall request for load-use, long-latency RAW/WAW and unit-full
// hazards. The ALU bypass network handles everything else.
module register_scoreboard #(
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rs1_id_i,
    input  logic [4:0]       rs2_id_i,
    input  logic             rs1_used_en,
    input  logic             rs2_used_en,
    input  logic [4:0]       rd_id_i,
    input  logic             reg_write_id_en,
    input  logic             issue_long_en,
    input  logic [4:0]       rd_id_ex_i,
    input  logic             mem_read_id_ex_en,
    input  logic             flush_en,
    input  logic             wb_long_valid_en,
    input  logic [4:0]       wb_long_rd_i,
    output logic             stall_o,
    output logic [31:0]      busy_vec_o,
    output logic [CNT_W-1:0] pending_count_o,
    output logic             error_o
);

    localparam logic [CNT_W-1:0] PENDING_MAX = CNT_W'(MAX_PENDING);

    // Bit 0 is held at zero so x0 can be indexed like any other register.
    logic [31:0]      busy_q;
    logic [CNT_W-1:0] pending_q;
    logic             error_q;

    logic             load_use;
    logic             raw_long;
    logic             waw_long;
    logic             unit_full;
    logic             stall;
    logic             issue;
    logic             comp_bad;
    logic             comp_ok;
    logic [31:0]      busy_nxt;
    logic [CNT_W-1:0] pending_nxt;

    // Hazard detection; a squashed instruction never stalls.
    always_comb begin
        load_use  = mem_read_id_ex_en && (rd_id_ex_i != 5'd0) &&
                    ((rs1_used_en && (rd_id_ex_i == rs1_id_i)) ||
                     (rs2_used_en && (rd_id_ex_i == rs2_id_i)));
        raw_long  = (rs1_used_en && busy_q[rs1_id_i]) ||
                    (rs2_used_en && busy_q[rs2_id_i]);
        waw_long  = reg_write_id_en && busy_q[rd_id_i];
        unit_full = issue_long_en && (pending_q == PENDING_MAX);
        stall     = !flush_en && (load_use || raw_long || waw_long || unit_full);
        issue     = issue_long_en && !stall && !flush_en;
    end

    // Classify a writeback: a completion for an idle unit or a non-busy
    // register is reported and otherwise ignored, which also keeps the
    // counter from underflowing.
    always_comb begin
        comp_bad = wb_long_valid_en &&
                   ((pending_q == '0) ||
                    ((wb_long_rd_i != 5'd0) && !busy_q[wb_long_rd_i]));
        comp_ok  = wb_long_valid_en && !comp_bad;
    end

    // Next busy vector and pending count. Clear happens before set; an issue
    // to the completing register is already blocked by the WAW stall.
    always_comb begin
        busy_nxt    = busy_q;
        pending_nxt = pending_q;
        if (comp_ok) begin
            busy_nxt[wb_long_rd_i] = 1'b0;
        end
        if (issue && reg_write_id_en && (rd_id_i != 5'd0)) begin
            busy_nxt[rd_id_i] = 1'b1;
        end
        unique case ({issue, comp_ok})
            2'b10:   pending_nxt = pending_q + CNT_W'(1);
            2'b01:   pending_nxt = pending_q - CNT_W'(1);
            default: pending_nxt = pending_q;
        endcase
    end

    // State registers; reset wins over any same-cycle issue or completion.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q    <= '0;
            pending_q <= '0;
            error_q   <= 1'b0;
        end else begin
            busy_q    <= {busy_nxt[31:1], 1'b0};
            pending_q <= pending_nxt;
            if (comp_bad) begin
                error_q <= 1'b1;
            end
        end
    end

    assign stall_o         = stall;
    assign busy_vec_o      = busy_q;
    assign pending_count_o = pending_q;
    assign error_o         = error_q;

endmodule

// File: tb/tb_register_scoreboard.sv
module tb_register_scoreboard;

    localparam int MAX_PENDING = 4;
    localparam int CNT_W       = $clog2(MAX_PENDING + 1);

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [4:0]       rs1_id_i, rs2_id_i, rd_id_i, rd_id_ex_i, wb_long_rd_i;
    logic             rs1_used_en, rs2_used_en, reg_write_id_en, issue_long_en;
    logic             mem_read_id_ex_en, flush_en, wb_long_valid_en;
    logic             stall_o;
    logic [31:0]      busy_vec_o;
    logic [CNT_W-1:0] pending_count_o;
    logic             error_o;

    int total = 0;
    int bad   = 0;

    register_scoreboard #(.MAX_PENDING(MAX_PENDING)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .rs1_id_i         (rs1_id_i),
        .rs2_id_i         (rs2_id_i),
        .rs1_used_en      (rs1_used_en),
        .rs2_used_en      (rs2_used_en),
        .rd_id_i          (rd_id_i),
        .reg_write_id_en  (reg_write_id_en),
        .issue_long_en    (issue_long_en),
        .rd_id_ex_i       (rd_id_ex_i),
        .mem_read_id_ex_en(mem_read_id_ex_en),
        .flush_en         (flush_en),
        .wb_long_valid_en (wb_long_valid_en),
        .wb_long_rd_i     (wb_long_rd_i),
        .stall_o          (stall_o),
        .busy_vec_o       (busy_vec_o),
        .pending_count_o  (pending_count_o),
        .error_o          (error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string    name;
        logic [4:0] rs1, rs2;
        logic     rs1u, rs2u;
        logic [4:0] rd;
        logic     rw, il;
        logic [4:0] rd_ex;
        logic     mr, fl;
        logic     exp_stall;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        rs1_id_i = 0; rs2_id_i = 0; rs1_used_en = 0; rs2_used_en = 0;
        rd_id_i = 0; reg_write_id_en = 0; issue_long_en = 0;
        rd_id_ex_i = 0; mem_read_id_ex_en = 0; flush_en = 0;
        wb_long_valid_en = 0; wb_long_rd_i = 0;
    endtask

    // Drive a long-unit issue and/or completion for one cycle.
    task automatic cycle_op(input logic il, input logic [4:0] rd,
                            input logic wb, input logic [4:0] wrd);
        @(negedge clk_i);
        idle();
        issue_long_en = il; reg_write_id_en = il; rd_id_i = rd;
        wb_long_valid_en = wb; wb_long_rd_i = wrd;
        @(posedge clk_i);
        #1 idle();
    endtask

    task automatic check_state(input string name, input logic [31:0] b,
                               input int p, input logic e);
        @(negedge clk_i);
        check({name, "_busy"}, busy_vec_o, b);
        check({name, "_pend"}, 32'(pending_count_o), 32'(p));
        check({name, "_err"}, 32'(error_o), 32'(e));
    endtask

    initial begin
        idle();
        // Reset with issue and completion asserted: reset must win.
        rst_i = 1;
        issue_long_en = 1; reg_write_id_en = 1; rd_id_i = 5'd6;
        wb_long_valid_en = 1; wb_long_rd_i = 5'd6;
        repeat (2) @(posedge clk_i);
        #1 check("reset_stall", 32'(stall_o), 0);
        rst_i = 0;
        idle();
        check_state("reset", 32'h0, 0, 0);
        check("reset_stall_idle", 32'(stall_o), 0);

        // Combinational stall vectors with empty scoreboard.
        //            name          rs1 rs2 u1 u2 rd rw il rdex mr fl exp
        vecs[0] = '{"lu_rs2",       0,  5,  0, 1, 0, 0, 0, 5,   1, 0, 1};
        vecs[1] = '{"lu_rs2_unused",0,  5,  0, 0, 0, 0, 0, 5,   1, 0, 0};
        vecs[2] = '{"lu_x0",        0,  0,  1, 1, 0, 0, 0, 0,   1, 0, 0};
        vecs[3] = '{"lu_rs1",       5,  2,  1, 1, 0, 0, 0, 5,   1, 0, 1};
        vecs[4] = '{"lu_flush",     5,  2,  1, 1, 0, 0, 0, 5,   1, 1, 0};
        vecs[5] = '{"no_load",      5,  5,  1, 1, 0, 0, 0, 5,   0, 0, 0};
        vecs[6] = '{"lu_other_rd",  4,  6,  1, 1, 0, 0, 0, 5,   1, 0, 0};
        vecs[7] = '{"idle_issue",   1,  2,  1, 1, 3, 1, 1, 0,   0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            rs1_id_i = vecs[i].rs1; rs2_id_i = vecs[i].rs2;
            rs1_used_en = vecs[i].rs1u; rs2_used_en = vecs[i].rs2u;
            rd_id_i = vecs[i].rd; reg_write_id_en = vecs[i].rw;
            issue_long_en = vecs[i].il; rd_id_ex_i = vecs[i].rd_ex;
            mem_read_id_ex_en = vecs[i].mr; flush_en = vecs[i].fl;
            #1 check(vecs[i].name, 32'(stall_o), 32'(vecs[i].exp_stall));
            // Keep the probe-only issue vector from reaching a clock edge.
            if (vecs[i].il) issue_long_en = 0;
            #1 idle();
        end
        check_state("after_vectors", 32'h0, 0, 0);

        // Long RAW: DIV to x7, consumer stalls until the cycle after writeback.
        cycle_op(1, 5'd7, 0, 0);
        check_state("div7", 32'h80, 1, 0);
        rs1_id_i = 5'd7; rs1_used_en = 1;
        #1 check("raw7_stall", 32'(stall_o), 1);
        wb_long_valid_en = 1; wb_long_rd_i = 5'd7;
        #1 check("raw7_stall_wb", 32'(stall_o), 1);
        @(posedge clk_i);
        #1 wb_long_valid_en = 0;
        @(negedge clk_i);
        check("raw7_release", 32'(stall_o), 0);
        check("raw7_busy", busy_vec_o, 32'h0);
        check("raw7_pend", 32'(pending_count_o), 0);
        idle();

        // Fill the unit.
        for (int r = 1; r <= 4; r++) cycle_op(1, 5'(r), 0, 0);
        check_state("full", 32'h1E, 4, 0);
        // Issue to x9 blocked while x2 completes in the same cycle.
        issue_long_en = 1; reg_write_id_en = 1; rd_id_i = 5'd9;
        wb_long_valid_en = 1; wb_long_rd_i = 5'd2;
        #1 check("full_stall", 32'(stall_o), 1);
        @(posedge clk_i);
        #1 idle();
        check_state("full_wb2", 32'h1A, 3, 0);
        issue_long_en = 1; reg_write_id_en = 1; rd_id_i = 5'd9;
        #1 check("retry_stall", 32'(stall_o), 0);
        @(posedge clk_i);
        #1 idle();
        check_state("retry9", 32'h21A, 4, 0);

        // WAW on x3, then the same with flush.
        reg_write_id_en = 1; rd_id_i = 5'd3;
        #1 check("waw_stall", 32'(stall_o), 1);
        issue_long_en = 1; flush_en = 1;
        #1 check("waw_flush", 32'(stall_o), 0);
        @(posedge clk_i);
        #1 idle();
        check_state("flush_noissue", 32'h21A, 4, 0);

        // Completion for a non-busy register.
        cycle_op(0, 0, 1, 5'd12);
        check_state("err12", 32'h21A, 4, 1);
        check_state("err12_sticky", 32'h21A, 4, 1);

        // Drain and reset.
        cycle_op(0, 0, 1, 5'd1);
        cycle_op(0, 0, 1, 5'd3);
        cycle_op(0, 0, 1, 5'd4);
        cycle_op(0, 0, 1, 5'd9);
        check_state("drained", 32'h0, 0, 1);
        @(negedge clk_i);
        rst_i = 1;
        @(posedge clk_i);
        #1 rst_i = 0;
        check_state("reset2", 32'h0, 0, 0);

        // rd=0 issue tracks occupancy only; then an underflow completion.
        cycle_op(1, 5'd0, 0, 0);
        check_state("issue_x0", 32'h0, 1, 0);
        cycle_op(0, 0, 1, 5'd0);
        check_state("wb_x0", 32'h0, 0, 0);
        cycle_op(0, 0, 1, 5'd0);
        check_state("underflow", 32'h0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/register_scoreboard.md
# register_scoreboard

Producer-side hazard tracker for the pipelined core. It resolves every RAW/WAW case the ALU bypass network cannot: load-use hazards and results from the multi-cycle MUL/DIV unit. It sits beside the ID stage and tracks, per architectural register, whether a long-latency write is outstanding. It drives a single stall request to the PC/IF-ID/ID-EX control, and clears entries when the long unit writes back.

## Interface
Parameters:
- MAX_PENDING, 4, maximum outstanding long-latency writes (1..31)
- CNT_W, $clog2(MAX_PENDING+1), width of pending counter

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous, active-high reset
- rs1_id_i  in  5  rs1 of instruction in ID
- rs2_id_i  in  5  rs2 of instruction in ID
- rs1_used_en  in  1  ID instruction reads rs1
- rs2_used_en  in  1  ID instruction reads rs2
- rd_id_i  in  5  rd of instruction in ID
- reg_write_id_en  in  1  ID instruction writes rd
- issue_long_en  in  1  ID instruction goes to MUL/DIV unit
- rd_id_ex_i  in  5  rd of instruction in ID/EX
- mem_read_id_ex_en  in  1  ID/EX instruction is a load
- flush_en  in  1  ID instruction is being squashed this cycle
- wb_long_valid_en  in  1  MUL/DIV result written back this cycle
- wb_long_rd_i  in  5  destination of that result
- stall_o  out  1  hold PC and IF/ID, bubble into ID/EX
- busy_vec_o  out  32  registered busy bit per register; bit 0 always 0
- pending_count_o  out  CNT_W  outstanding long writes
- error_o  out  1  sticky: completion for non-busy register

## Operation
- State: busy[31:1], pending counter, error flag. Register x0 is never busy.
- stall_o is combinational from current inputs and registered state. It is the OR of:
  - load-use: mem_read_id_ex_en && rd_id_ex_i!=0 && ((rs1_used_en && rd_id_ex_i==rs1_id_i) || (rs2_used_en && rd_id_ex_i==rs2_id_i))
  - RAW-long: rs1_used_en && busy[rs1_id_i], or rs2_used_en && busy[rs2_id_i]
  - WAW-long: reg_write_id_en && busy[rd_id_i]
  - structural: issue_long_en && pending==MAX_PENDING
- All stall terms are masked to 0 when flush_en=1, because a squashed instruction never stalls.
- Issue occurs when issue_long_en && !stall_o && !flush_en. On issue:
  - set busy[rd_id_i] if reg_write_id_en && rd_id_i!=0
  - pending += 1 (this also applies when rd=0, which tracks unit occupancy)
- Completion occurs when wb_long_valid_en:
  - pending -= 1 and busy[wb_long_rd_i] cleared
  - Exception: if pending==0, or wb_long_rd_i!=0 and busy[wb_long_rd_i]==0, no state changes and error_o sets. error_o stays set until reset.
- Simultaneous issue and completion: net pending unchanged.
  - Issue to the register completing in that cycle cannot happen, because the registered busy bit still stalls it (WAW).
  - Issue to a different register sets its bit while the completing bit clears.
- Counter never wraps; the structural stall prevents overflow and the error path prevents underflow.

## Timing
- Reset, synchronous on rst_i high at a clock edge: busy_vec_o=0, pending_count_o=0, error_o=0. rst_i takes priority over issue and completion in the same cycle.
- stall_o after reset = load-use term only.
- Reset mid-operation drops all pending entries. The MUL/DIV unit is reset by the same rst_i.
- busy_vec_o, pending_count_o, and error_o update on the clock edge following issue or completion.
- No result bypass from completion: a consumer stalled on busy[r] is released one cycle after the wb_long_valid_en cycle for r. It then reads r through the normal MEM/WB forward or the register file.
- The load-use stall lasts exactly 1 cycle per load, after which the load is in EX/MEM and the bypass network covers it.

## Test plan
- Reset: hold rst_i 2 cycles with issue_long_en=1, wb_long_valid_en=1 -> busy_vec_o=0, pending_count_o=0, error_o=0, stall_o=0.
- Load-use: ID/EX load rd=5, ID reads rs2=5 -> stall_o=1 for 1 cycle. With rs2_used_en=0 -> stall_o=0. Load with rd=0, ID reads x0 -> stall_o=0.
- Long RAW: issue DIV rd=7. Next cycle busy_vec_o=0x80 and pending=1. ID reads rs1=7 -> stall_o=1. Completion rd=7 in cycle N -> busy clear at N+1, stall_o=0 at N+1.
- Structural/overflow (MAX_PENDING=4): issue to rd=1..4 -> pending=4. Issue to rd=9 -> stall_o=1, no state change. Completion rd=2 in the same cycle -> next cycle pending=3, busy_vec_o=0x1A. Retry issue to rd=9 -> pending=4, busy_vec_o=0x21A.
- WAW plus flush: busy[3]=1 and ID writes rd=3 -> stall_o=1. Same stimulus with flush_en=1 -> stall_o=0 and no issue.
- Error: completion rd=12 with busy[12]=0 -> error_o=1 next cycle and stays set; pending and busy_vec_o are unchanged.
